// File: rtl/seg_scan_decoder_if.sv
// Frame output bus of seg_scan_decoder: one decoded 4-digit frame under a
// valid/ready handshake.
interface seg_scan_decoder_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] digits_out;
  logic [3:0]  dp_out;
  logic [3:0]  digit_err;

  modport master (
    output frame_valid,
    output digits_out,
    output dp_out,
    output digit_err,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  digits_out,
    input  dp_out,
    input  digit_err,
    output frame_ready
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Samples multiplexed 7-segment pins, captures each digit once its pattern has
// settled, decodes it to hex and emits completed 4-digit frames on a handshake.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES   = 2,
  parameter bit SEL_ACTIVE_HIGH = 1'b1,
  parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 seg_in,
  input  logic [3:0]                 sel_in,
  seg_scan_decoder_if.master         frame_if,
  output logic                       overrun
);

  localparam logic [3:0] STABLE_VAL = 4'(STABLE_CYCLES);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  logic [11:0] sample_q, sample_d;
  logic [11:0] prev_q, prev_d;
  logic [3:0]  stab_cnt_q, stab_cnt_d;

  logic [3:0]  mask_q, mask_d;
  logic [15:0] stage_nib_q, stage_nib_d;
  logic [3:0]  stage_dp_q, stage_dp_d;
  logic [3:0]  stage_err_q, stage_err_d;

  slot_state_e state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  err_q, err_d;
  logic        overrun_q, overrun_d;

  logic [3:0]  sel_norm;
  logic [7:0]  seg_norm;
  logic        sel_onehot;
  logic        same_sample;
  logic        capture;
  logic        frame_complete;
  logic [4:0]  decoded;

  function automatic logic [4:0] decode_glyph(input logic [6:0] glyph);
    logic [4:0] res;
    case (glyph)
      7'h3F:   res = 5'h00;
      7'h06:   res = 5'h01;
      7'h5B:   res = 5'h02;
      7'h4F:   res = 5'h03;
      7'h66:   res = 5'h04;
      7'h6D:   res = 5'h05;
      7'h7D:   res = 5'h06;
      7'h07:   res = 5'h07;
      7'h7F:   res = 5'h08;
      7'h6F:   res = 5'h09;
      7'h77:   res = 5'h0A;
      7'h7C:   res = 5'h0B;
      7'h39:   res = 5'h0C;
      7'h5E:   res = 5'h0D;
      7'h79:   res = 5'h0E;
      7'h71:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  // Comparison is done on the raw registered pins; polarity only matters once
  // the sample is interpreted.
  always_comb begin
    sample_d    = {sel_in, seg_in};
    prev_d      = sample_q;
    sel_norm    = SEL_ACTIVE_HIGH ? sample_q[11:8] : ~sample_q[11:8];
    seg_norm    = SEG_ACTIVE_HIGH ? sample_q[7:0]  : ~sample_q[7:0];
    sel_onehot  = (sel_norm != 4'd0) && ((sel_norm & (sel_norm - 4'd1)) == 4'd0);
    same_sample = (sample_q == prev_q);
    decoded     = decode_glyph(seg_norm[6:0]);

    if (!same_sample) begin
      stab_cnt_d = 4'd1;
    end else if (stab_cnt_q != 4'hF) begin
      stab_cnt_d = stab_cnt_q + 4'd1;
    end else begin
      stab_cnt_d = stab_cnt_q;
    end

    // A saturated count that already sits at the threshold must not recapture.
    capture = sel_onehot && (stab_cnt_d == STABLE_VAL) &&
              (!same_sample || (stab_cnt_q != STABLE_VAL));
  end

  always_comb begin
    frame_complete = (mask_q == 4'hF);
    mask_d         = (frame_complete ? 4'd0 : mask_q) | (capture ? sel_norm : 4'd0);
    stage_nib_d    = stage_nib_q;
    stage_dp_d     = stage_dp_q;
    stage_err_d    = stage_err_q;
    for (int i = 0; i < 4; i++) begin
      if (capture && sel_norm[i]) begin
        stage_nib_d[4*i +: 4] = decoded[3:0];
        stage_dp_d[i]         = seg_norm[7];
        stage_err_d[i]        = decoded[4];
      end
    end
  end

  // A completed frame is accepted when the slot is empty or being drained in
  // the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    dp_d      = dp_q;
    err_d     = err_q;
    overrun_d = overrun_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (frame_complete) begin
          digits_d = stage_nib_q;
          dp_d     = stage_dp_q;
          err_d    = stage_err_q;
          state_d  = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (frame_complete) begin
          if (frame_if.frame_ready) begin
            digits_d = stage_nib_q;
            dp_d     = stage_dp_q;
            err_d    = stage_err_q;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (frame_if.frame_ready) begin
          state_d = SLOT_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q    <= '0;
      prev_q      <= '0;
      stab_cnt_q  <= '0;
      mask_q      <= '0;
      stage_nib_q <= '0;
      stage_dp_q  <= '0;
      stage_err_q <= '0;
      state_q     <= SLOT_EMPTY;
      digits_q    <= '0;
      dp_q        <= '0;
      err_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      prev_q      <= prev_d;
      stab_cnt_q  <= stab_cnt_d;
      mask_q      <= mask_d;
      stage_nib_q <= stage_nib_d;
      stage_dp_q  <= stage_dp_d;
      stage_err_q <= stage_err_d;
      state_q     <= state_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_if.frame_valid = (state_q == SLOT_FULL);
  assign frame_if.digits_out  = digits_q;
  assign frame_if.dp_out      = dp_q;
  assign frame_if.digit_err   = err_q;
  assign overrun              = overrun_q;

endmodule
